// File: rtl/gpo_commaalign_ctrl.sv
// Comma-align control for one GT lane: brings the GPO request bit into the RX user-clock
// domain and sequences rxcommaalignen through align/lock/timeout, reporting in GPI layout.
module gpo_commaalign_ctrl #(
    parameter int unsigned CHANNEL_ID     = 2,
    parameter int unsigned LOCK_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] gpo_in,
    input  logic        rxbyteisaligned,
    input  logic        rxbyterealign,
    output logic        rxcommaalignen_out,
    output logic        align_locked,
    output logic        align_timeout,
    output logic [15:0] status_out
);

    localparam int unsigned LockW = $clog2(LOCK_CYCLES);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES);

    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_CYCLES - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

    if (CHANNEL_ID > 3) begin : gen_bad_channel
        $error("CHANNEL_ID must be in 0..3");
    end
    if (LOCK_CYCLES < 2) begin : gen_bad_lock
        $error("LOCK_CYCLES must be at least 2");
    end
    if (TIMEOUT_CYCLES <= LOCK_CYCLES) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must exceed LOCK_CYCLES");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StLocked,
        StFail
    } state_e;

    state_e           state_q, state_d;
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic             req_meta_q, req_meta_d;
    logic             req_q, req_d;
    logic             align_en_q, align_en_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             clean;

    // Only the channel's request bit crosses domains; the rest of the word is don't-care here.
    logic unused_gpo;
    assign unused_gpo = ^gpo_in;

    assign clean = rxbyteisaligned & ~rxbyterealign;

    always_comb begin
        req_meta_d = gpo_in[CHANNEL_ID+8];
        req_d      = req_meta_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_meta_q <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            req_meta_q <= req_meta_d;
            req_q      <= req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;

        case (state_q)
            StIdle: begin
                if (req_q) begin
                    state_d    = StAlign;
                    lock_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end
            end
            StAlign: begin
                // Lock is tested before timeout so a simultaneous finish resolves to lock.
                if (!req_q) begin
                    state_d = StIdle;
                end else if (clean && (lock_cnt_q == LockLast)) begin
                    state_d = StLocked;
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d = StFail;
                end else begin
                    lock_cnt_d = clean ? lock_cnt_q + 1'b1 : '0;
                    tmo_cnt_d  = tmo_cnt_q + 1'b1;
                end
            end
            StLocked: begin
                if (!req_q) begin
                    state_d = StIdle;
                end else if (!clean) begin
                    state_d    = StAlign;
                    lock_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end
            end
            StFail: begin
                if (!req_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state register.
    always_comb begin
        align_en_d = (state_d == StAlign);
        locked_d   = (state_d == StLocked);
        timeout_d  = (state_d == StFail);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            lock_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            align_en_q <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            align_en_q <= align_en_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rxcommaalignen_out = align_en_q;
    assign align_locked       = locked_q;
    assign align_timeout      = timeout_q;

    always_comb begin
        status_out               = '0;
        status_out[CHANNEL_ID]   = locked_q;
        status_out[CHANNEL_ID+4] = timeout_q;
        status_out[CHANNEL_ID+8] = align_en_q;
    end

endmodule

// File: tb/tb_gpo_commaalign_ctrl.sv
// Bench for gpo_commaalign_ctrl: directed lane scenarios then random traffic, two lanes
// (channels 2 and 0) sharing stimulus, checked against a cycle-level behavioural model.
module tb_gpo_commaalign_ctrl;

    localparam int unsigned ChA   = 2;
    localparam int unsigned ChB   = 0;
    localparam int unsigned LockN = 16;
    localparam int unsigned TmoN  = 100;

    localparam int MIdle = 0;
    localparam int MHunt = 1;
    localparam int MLock = 2;
    localparam int MFail = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] gpo_in;
    logic        rxbyteisaligned;
    logic        rxbyterealign;
    logic        en_a, lk_a, to_a, en_b, lk_b, to_b;
    logic [15:0] st_a, st_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode, length of current clean run, cycles spent hunting, request delay line.
    int m_mode [2];
    int m_run  [2];
    int m_age  [2];
    bit m_s1   [2];
    bit m_s2   [2];

    always #5 clk = ~clk;

    gpo_commaalign_ctrl #(
        .CHANNEL_ID    (ChA),
        .LOCK_CYCLES   (LockN),
        .TIMEOUT_CYCLES(TmoN)
    ) u_dut_a (
        .clk               (clk),
        .resetn            (resetn),
        .gpo_in            (gpo_in),
        .rxbyteisaligned   (rxbyteisaligned),
        .rxbyterealign     (rxbyterealign),
        .rxcommaalignen_out(en_a),
        .align_locked      (lk_a),
        .align_timeout     (to_a),
        .status_out        (st_a)
    );

    gpo_commaalign_ctrl #(
        .CHANNEL_ID    (ChB),
        .LOCK_CYCLES   (LockN),
        .TIMEOUT_CYCLES(TmoN)
    ) u_dut_b (
        .clk               (clk),
        .resetn            (resetn),
        .gpo_in            (gpo_in),
        .rxbyteisaligned   (rxbyteisaligned),
        .rxbyterealign     (rxbyterealign),
        .rxcommaalignen_out(en_b),
        .align_locked      (lk_b),
        .align_timeout     (to_b),
        .status_out        (st_b)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ch_of(input int d);
        return (d == 0) ? ChA : ChB;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = MIdle;
            m_run[d]  = 0;
            m_age[d]  = 0;
            m_s1[d]   = 1'b0;
            m_s2[d]   = 1'b0;
        end
    endfunction

    // One rising edge of the lane, using the inputs currently applied.
    function automatic void model_edge();
        bit req;
        bit good;
        for (int d = 0; d < 2; d++) begin
            req  = m_s2[d];
            good = rxbyteisaligned && !rxbyterealign;
            case (m_mode[d])
                MIdle: if (req) begin
                    m_mode[d] = MHunt;
                    m_run[d]  = 0;
                    m_age[d]  = 0;
                end
                MHunt: begin
                    if (!req) m_mode[d] = MIdle;
                    else if (good && (m_run[d] + 1 == int'(LockN))) m_mode[d] = MLock;
                    else if (m_age[d] + 1 == int'(TmoN)) m_mode[d] = MFail;
                    else begin
                        m_run[d] = good ? m_run[d] + 1 : 0;
                        m_age[d] = m_age[d] + 1;
                    end
                end
                MLock: begin
                    if (!req) m_mode[d] = MIdle;
                    else if (!good) begin
                        m_mode[d] = MHunt;
                        m_run[d]  = 0;
                        m_age[d]  = 0;
                    end
                end
                default: if (!req) m_mode[d] = MIdle;
            endcase
            m_s2[d] = m_s1[d];
            m_s1[d] = gpo_in[ch_of(d) + 8];
        end
    endfunction

    function automatic logic [15:0] exp_status(input int d);
        logic [15:0] s;
        s = '0;
        s[ch_of(d)]     = (m_mode[d] == MLock);
        s[ch_of(d) + 4] = (m_mode[d] == MFail);
        s[ch_of(d) + 8] = (m_mode[d] == MHunt);
        return s;
    endfunction

    function automatic logic [15:0] exp_pins(input int d);
        return {13'b0, m_mode[d] == MHunt, m_mode[d] == MLock, m_mode[d] == MFail};
    endfunction

    task automatic compare_all();
        check_eq("status_ch2", st_a, exp_status(0));
        check_eq("pins_ch2", {13'b0, en_a, lk_a, to_a}, exp_pins(0));
        check_eq("status_ch0", st_b, exp_status(1));
        check_eq("pins_ch0", {13'b0, en_b, lk_b, to_b}, exp_pins(1));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Called #1 after a rising edge; releases #1 after the following edge.
    task automatic reset_pulse();
        resetn = 1'b0;
        #1;
        check_eq("rst_async_en", {15'b0, en_a}, 16'h0);
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        resetn = 1'b1;
    endtask

    initial begin
        int prob;
        resetn          = 1'b0;
        gpo_in          = 16'h0400;
        rxbyteisaligned = 1'b0;
        rxbyterealign   = 1'b0;
        model_reset();
        #1;
        check_eq("rst_status", st_a, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        resetn = 1'b1;

        step(); check_eq("lat_edge1", {15'b0, en_a}, 16'h0);
        step(); check_eq("lat_edge2", {15'b0, en_a}, 16'h0);
        step(); check_eq("lat_edge3", st_a, 16'h0400);
        check_eq("iso_ch0_bit10", st_b, 16'h0000);

        rxbyteisaligned = 1'b1;
        repeat (15) step();
        check_eq("lock_pre", st_a, 16'h0400);
        step(); check_eq("lock16", st_a, 16'h0004);

        rxbyterealign = 1'b1;
        step(); check_eq("realign", st_a, 16'h0400);
        rxbyterealign = 1'b0;
        repeat (9) step();
        rxbyteisaligned = 1'b0;
        step();
        rxbyteisaligned = 1'b1;
        repeat (15) step();
        check_eq("drop_lock_pre", st_a, 16'h0400);
        step(); check_eq("drop_lock16", st_a, 16'h0004);

        rxbyteisaligned = 1'b0;
        step(); check_eq("tmo_enter", st_a, 16'h0400);
        repeat (99) step();
        check_eq("tmo_pre", st_a, 16'h0400);
        step(); check_eq("tmo100", st_a, 16'h0040);
        repeat (5) step();
        check_eq("fail_hold", st_a, 16'h0040);

        gpo_in = 16'h0000;
        repeat (3) step();
        check_eq("toggle_idle", st_a, 16'h0000);
        gpo_in = 16'h0400;
        repeat (3) step();
        check_eq("toggle_align", st_a, 16'h0400);

        repeat (84) step();
        rxbyteisaligned = 1'b1;
        repeat (15) step();
        check_eq("both_pre", st_a, 16'h0400);
        step(); check_eq("lock_vs_tmo", st_a, 16'h0004);

        rxbyterealign = 1'b1;
        step();
        rxbyterealign = 1'b0;
        repeat (13) step();
        gpo_in = 16'h0000;
        repeat (2) step();
        check_eq("drop_pre", st_a, 16'h0400);
        step(); check_eq("drop_vs_lock", st_a, 16'h0000);

        gpo_in = 16'h0400;
        repeat (3) step();
        check_eq("mid_align", st_a, 16'h0400);
        reset_pulse();

        gpo_in = 16'h0100;
        repeat (3) step();
        check_eq("ch0_bit8", st_b, 16'h0100);
        check_eq("ch2_ignores_bit8", st_a, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 3)
                0:       prob = 98;
                1:       prob = 50;
                default: prob = 3;
            endcase
            gpo_in = (gpo_in & 16'h0500) | (16'($urandom) & ~16'h0500);
            if ($urandom_range(0, 39) == 0) gpo_in[10] = ~gpo_in[10];
            if ($urandom_range(0, 39) == 0) gpo_in[8] = ~gpo_in[8];
            rxbyteisaligned = ($urandom_range(0, 99) < prob);
            rxbyterealign   = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 799) == 0) reset_pulse();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpo_commaalign_ctrl.md
Name: gpo_commaalign_ctrl

Overview:
Return-path control for a PL 1000BASE-X/2500BASE-X lane. Processor software writes a 16-bit GPO word. For its channel, this block extracts the comma-align request bit CHANNEL_ID+8 and synchronizes it into the transceiver RX user-clock domain. It then runs an align/lock/timeout state machine that drives the GT rxcommaalignen pin and reports lane status in the same bit layout as the GPI status word, so software reads back through its GPI input.

Parameters:
CHANNEL_ID, 2, lane index; legal range 0..3; selects GPO/GPI bit positions
LOCK_CYCLES, 16, consecutive clean aligned cycles required to declare lock; minimum 2
TIMEOUT_CYCLES, 65535, cycles allowed in ALIGN before declaring failure; must be greater than LOCK_CYCLES

Ports:
clk  input  1  GT RX user clock; all logic on rising edge
resetn  input  1  asynchronous active-low reset
gpo_in  input  16  GPO word from processor domain; asynchronous to clk
rxbyteisaligned  input  1  GT byte-aligned status, synchronous to clk
rxbyterealign  input  1  GT realign pulse, synchronous to clk
rxcommaalignen_out  output  1  comma-align enable to GT
align_locked  output  1  lane locked
align_timeout  output  1  alignment failed
status_out  output  16  GPI-format status word

Behaviour:
- Reset (resetn low, asynchronous): synchronizer flops, counters, and outputs go to 0; state goes to IDLE. Release is synchronous to clk. Asserting reset mid-ALIGN or mid-LOCKED immediately drops rxcommaalignen_out.
- Synchronizer: 2-flop chain on gpo_in[CHANNEL_ID+8] only. req = output of the second flop. All other gpo_in bits are ignored.
- State register: 2 bits. States are IDLE, ALIGN, LOCKED, FAIL.
- Outputs are registered decodes of the next state, so they update on the same edge as the state register.
  - rxcommaalignen_out = 1 only in ALIGN.
  - align_locked = 1 only in LOCKED.
  - align_timeout = 1 only in FAIL.
- Latency: a 0->1 change on gpo bit CHANNEL_ID+8 (setup met) produces rxcommaalignen_out=1 at the 3rd rising edge.
- clean = rxbyteisaligned & ~rxbyterealign.
- IDLE:
  - req=1 -> ALIGN; lock_cnt and tmo_cnt cleared to 0.
- ALIGN (priority order):
  - req=0 -> IDLE.
  - else clean and lock_cnt==LOCK_CYCLES-1 -> LOCKED.
  - else tmo_cnt==TIMEOUT_CYCLES-1 -> FAIL. If lock and timeout complete on the same cycle, lock wins.
  - else lock_cnt increments when clean and clears to 0 when not clean; tmo_cnt increments every cycle.
- LOCKED:
  - req=0 -> IDLE.
  - else ~clean -> ALIGN, with both counters cleared (automatic re-align; tmo_cnt restarts).
- FAIL:
  - Holds until req=0 -> IDLE. No automatic retry; software must toggle the bit 1->0->1.
- Counter widths:
  - lock_cnt is $clog2(LOCK_CYCLES) bits.
  - tmo_cnt is $clog2(TIMEOUT_CYCLES) bits.
  - Neither counter wraps: each leaves ALIGN before reaching its terminal count +1.
- status_out: all bits 0 except
  - bit CHANNEL_ID = align_locked
  - bit CHANNEL_ID+4 = align_timeout
  - bit CHANNEL_ID+8 = rxcommaalignen_out
  - status_out is combinational from the registered outputs and adds no extra latency.
- gpo_in glitch shorter than one clk period: may be missed or seen for one cycle. A one-cycle req produces IDLE->ALIGN->IDLE, with rxcommaalignen_out high for exactly 1 cycle. This is legal.

Test Plan:
- Reset with gpo_in=16'h0400 held: all outputs 0 during reset. After release, rxcommaalignen_out=1 at the 3rd edge and status_out=16'h0400.
- Lock (LOCK_CYCLES=16): in ALIGN, rxbyteisaligned=1 and rxbyterealign=0 for 16 cycles -> on the 16th edge rxcommaalignen_out=0, align_locked=1, status_out=16'h0004. Repeat with a single-cycle drop at cycle 10 -> lock only after 16 further clean cycles.
- Timeout (TIMEOUT_CYCLES=100): req=1, rxbyteisaligned=0 -> after exactly 100 cycles in ALIGN, align_timeout=1 and status_out=16'h0040. Toggling gpo bit 10 low then high -> IDLE, then ALIGN with counters at 0.
- Realign: in LOCKED, pulse rxbyterealign for 1 cycle -> next edge rxcommaalignen_out=1, align_locked=0, followed by a fresh 16-cycle lock sequence.
- Simultaneous events:
  - Lock terminal count and timeout terminal count on the same cycle -> LOCKED.
  - req drop on the same cycle as lock completion -> IDLE, all outputs 0.
- Mid-operation reset and isolation: assert resetn=0 while in ALIGN -> rxcommaalignen_out drops immediately, without waiting for a clock. With CHANNEL_ID=0, writing gpo_in=16'h0400 produces no response; only bit 8 is honoured.
